// File: rtl/demux12.sv
// Routes 10-bit upstream words to one of two FIFOs by in_data[8], with a
// single-entry holding register that absorbs a word whose target FIFO is full.
module demux12 #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [9:0]           in_data,
  output logic                 in_ready,
  input  logic                 fifo_full0,
  input  logic                 fifo_full1,
  output logic                 push0,
  output logic [7:0]           data0,
  output logic                 push1,
  output logic [7:0]           data1,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t               r_state;
  logic [7:0]           r_held_data;
  logic                 r_held_dest;
  logic                 r_push0;
  logic                 r_push1;
  logic [7:0]           r_data0;
  logic [7:0]           r_data1;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  state_t     w_state_next;
  logic       w_accept;
  logic       w_in_full;
  logic       w_held_full;
  logic       w_push0_next;
  logic       w_push1_next;
  logic [7:0] w_push_data;
  logic       w_hold_load;
  logic       w_unused_reserved;

  // Bit 9 is reserved and deliberately has no effect on the datapath.
  assign w_unused_reserved = in_data[9];

  assign in_ready    = (r_state == S_EMPTY) && !reset;
  assign w_accept    = in_valid && in_ready;
  assign w_in_full   = in_data[8] ? fifo_full1 : fifo_full0;
  assign w_held_full = r_held_dest ? fifo_full1 : fifo_full0;

  always_comb begin
    w_state_next = r_state;
    w_push0_next = 1'b0;
    w_push1_next = 1'b0;
    w_push_data  = r_held_data;
    w_hold_load  = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          if (w_in_full) begin
            w_hold_load  = 1'b1;
            w_state_next = S_HELD;
          end else begin
            w_push0_next = ~in_data[8];
            w_push1_next = in_data[8];
            w_push_data  = in_data[7:0];
          end
        end
      end
      S_HELD: begin
        // Only the held word's own destination can release it.
        if (!w_held_full) begin
          w_push0_next = ~r_held_dest;
          w_push1_next = r_held_dest;
          w_state_next = S_EMPTY;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_held_data <= 8'h00;
      r_held_dest <= 1'b0;
      r_push0     <= 1'b0;
      r_push1     <= 1'b0;
      r_data0     <= 8'h00;
      r_data1     <= 8'h00;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      r_state <= w_state_next;
      r_push0 <= w_push0_next;
      r_push1 <= w_push1_next;
      if (w_hold_load) begin
        r_held_data <= in_data[7:0];
        r_held_dest <= in_data[8];
      end
      if (w_push0_next) begin
        r_data0 <= w_push_data;
        r_cnt0  <= r_cnt0 + 1'b1;
      end
      if (w_push1_next) begin
        r_data1 <= w_push_data;
        r_cnt1  <= r_cnt1 + 1'b1;
      end
    end
  end

  assign push0 = r_push0;
  assign push1 = r_push1;
  assign data0 = r_data0;
  assign data1 = r_data1;
  assign cnt0  = r_cnt0;
  assign cnt1  = r_cnt1;

endmodule

// File: doc/demux12.md
DEMUX12 -- requirements
Module: demux12

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8: width of the per-port routed-word counters.
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  upstream word present on in_data.
REQ-005 in_data  input  10  [7:0] payload, [8] destination (0 -> FIFO #0, 1 -> FIFO #1), [9] reserved and ignored.
REQ-006 in_ready  output  1  block accepts in_data this cycle when high.
REQ-007 fifo_full0  input  1  FIFO #0 cannot take a push next cycle (almost-full, one-entry margin).
REQ-008 fifo_full1  input  1  same for FIFO #1.
REQ-009 push0  output  1  registered write strobe to FIFO #0.
REQ-010 data0  output  8  payload to FIFO #0, valid while push0 is high.
REQ-011 push1  output  1  registered write strobe to FIFO #1.
REQ-012 data1  output  8  payload to FIFO #1, valid while push1 is high.
REQ-013 cnt0  output  CNT_WIDTH  count of words pushed to FIFO #0.
REQ-014 cnt1  output  CNT_WIDTH  count of words pushed to FIFO #1.

Function
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_valid with in_ready=0 is ignored, and upstream holds the word.
REQ-016 The block SHALL use two states: EMPTY (no word held) and HELD (one stalled word in the holding register, with its payload and destination).
REQ-017 in_ready SHALL be combinational: 1 when state=EMPTY and reset=0, otherwise 0.
REQ-018 In EMPTY, on a transfer with destination d where fifo_full_d=0 in the same cycle: push_d=1 and data_d=payload in the next cycle (latency 1); state stays EMPTY.
REQ-019 In EMPTY, on a transfer with destination d where fifo_full_d=1: the word SHALL be captured into the holding register, state -> HELD, and no push occurs.
REQ-020 In HELD, each cycle the held destination's full input is 0, the held word SHALL be pushed on the next edge (push_d=1, data_d=held payload) and state -> EMPTY; while it is 1, state stays HELD with no push.
REQ-021 In HELD, only the held destination's full input SHALL be considered; the other FIFO's full state has no effect.
REQ-022 At most one of push0/push1 SHALL be high in any cycle; each is a one-cycle pulse per word.
REQ-023 data0/data1 SHALL update only when the matching push is asserted and hold their last value otherwise.
REQ-024 Word order SHALL be preserved; no word is dropped or duplicated.
REQ-025 Sustained throughput SHALL be one word per cycle while the target FIFOs are not full.
REQ-026 cnt_d SHALL increment by 1 in the same cycle push_d asserts and wrap from 2^CNT_WIDTH-1 to 0.
REQ-027 in_data[9] SHALL have no effect on any output.

Reset
REQ-028 While reset=1 at a rising edge: state -> EMPTY, holding register cleared, push0=push1=0, data0=data1=0, cnt0=cnt1=0.
REQ-029 While reset=1, in_ready SHALL be 0.
REQ-030 A word held when reset asserts SHALL be discarded and never pushed.
REQ-031 A transfer presented in the cycle reset is high SHALL be ignored.
REQ-032 The first transfer SHALL be possible in the first cycle after reset deasserts.

Verification
REQ-033 Reset, then stream 0x0A5, 0x15A, 0x033 with both full=0 -> push0 with 0xA5 at cycle+1, push1 with 0x5A at cycle+2, push0 with 0x33 at cycle+3; cnt0=2, cnt1=1.
REQ-034 fifo_full1=1, send 0x1C3 -> in_ready=0 and no push; drop fifo_full1 after 3 cycles -> push1 with 0xC3 one cycle later, then in_ready=1.
REQ-035 Hold fifo_full0=1 with word 0x011 held, send traffic to FIFO #1 -> no push1 occurs and in_ready stays 0 until the held word is pushed.
REQ-036 Push 256 words to FIFO #0 with CNT_WIDTH=8 -> cnt0 wraps to 0x00; cnt1 stays 0.
REQ-037 Assert reset for one cycle while in HELD -> no push ever occurs for the held word; all outputs are 0 the following cycle; in_ready=1 once reset is low.
REQ-038 Send in_data=0x2FF vs 0x0FF under identical conditions -> identical push0/data0 (0xFF) behaviour.
